// File: rtl/psx_pkg.sv
// Shared constants and state encoding for the PSX pad bus master.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_CMD_IDLE   = 8'h00;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_ID_READY   = 8'h5A;

    // Index of the final byte of a digital-pad poll (bytes 0..4).
    localparam logic [2:0] PSX_LAST_BYTE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_ACKW,
        ST_GAP,
        ST_FIN,
        ST_ABORT
    } psx_state_t;

    // Command byte sent in each position of the poll.
    function automatic logic [7:0] psx_cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return PSX_CMD_START;
            3'd1:    return PSX_CMD_POLL;
            default: return PSX_CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_sync.sv
// Two-flop synchroniser for the asynchronous pad lines; resets to the
// bus idle level so a reset never looks like a falling edge.
module psx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/psx_poller.sv
// Console-side PSX controller bus master: runs one 5-byte digital-pad
// poll per start request and publishes the 16 button bits.
module psx_poller
    import psx_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int ATT_SETUP   = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int BYTE_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data,
    input  logic        ack,
    output logic        psx_clk,
    output logic        cmd,
    output logic        att,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    localparam int CNT_MAX_A = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
    localparam int CNT_MAX_B = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ATT_SETUP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);

    psx_state_t       state;
    psx_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte1;
    logic [7:0]       rx_byte2;
    logic [7:0]       rx_byte3;
    logic [7:0]       rx_next;
    logic [7:0]       cmd_cur;
    logic             data_s;
    logic             ack_s;
    logic             ack_s_d;
    logic             ack_fall;
    logic             bit_done;
    logic             id_ok;

    psx_sync u_data_sync (.clk(clk), .rst(rst), .d(data), .q(data_s));
    psx_sync u_ack_sync  (.clk(clk), .rst(rst), .d(ack),  .q(ack_s));

    assign ack_fall = ack_s_d & ~ack_s;
    assign rx_next  = {data_s, rx_shift[7:1]};
    assign cmd_cur  = psx_cmd_byte(byte_idx);
    assign id_ok    = (rx_byte1 == PSX_ID_DIGITAL) && (rx_byte2 == PSX_ID_READY);

    // State register; reset drops straight to IDLE so the bus releases at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and bus line levels (bus idles high, att high outside a poll).
    always_comb begin
        state_nxt = state;
        psx_clk   = 1'b1;
        cmd       = 1'b1;
        att       = 1'b0;
        busy      = 1'b1;
        bit_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                att  = 1'b1;
                busy = 1'b0;
                if (start) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                psx_clk = 1'b0;
                cmd     = cmd_cur[bit_idx];
                if (cnt == DIV_LAST) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                cmd = cmd_cur[bit_idx];
                if (cnt == DIV_LAST) begin
                    bit_done = 1'b1;
                    if (bit_idx != 3'd7)               state_nxt = ST_LOW;
                    else if (byte_idx == PSX_LAST_BYTE) state_nxt = ST_FIN;
                    else                                state_nxt = ST_ACKW;
                end
            end
            ST_ACKW: begin
                if (ack_fall)             state_nxt = ST_GAP;
                else if (cnt == ACK_LAST) state_nxt = ST_ABORT;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_nxt = ST_LOW;
            end
            ST_FIN: begin
                att       = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                att       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                att       = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase counter restarts on every state change; bit/byte indices follow the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            ack_s_d  <= 1'b1;
        end else begin
            ack_s_d <= ack_s;
            cnt     <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            if (state == ST_IDLE) begin
                bit_idx  <= '0;
                byte_idx <= '0;
            end else begin
                if (bit_done) bit_idx <= bit_idx + 3'd1;
                if (state == ST_GAP && state_nxt == ST_LOW) byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    // Receive shifter (LSB first) and capture of the ID and first button byte.
    always_ff @(posedge clk) begin
        if (bit_done) begin
            rx_shift <= rx_next;
            if (bit_idx == 3'd7) begin
                case (byte_idx)
                    3'd1:    rx_byte1 <= rx_next;
                    3'd2:    rx_byte2 <= rx_next;
                    3'd3:    rx_byte3 <= rx_next;
                    default: ;
                endcase
            end
        end
    end

    // Result flags pulse the cycle after att rises; buttons change only on a clean poll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buttons <= 16'hFFFF;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (state == ST_FIN) begin
                if (id_ok) begin
                    buttons <= {rx_shift, rx_byte3};
                    valid   <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end
            if (state == ST_ABORT) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psx_poller.sv
// Bench for psx_poller: a pad model answers on the bus, a monitor checks the
// bus and result flags every cycle, and a transaction-level model predicts
// each poll's outcome from the pad's configured reply.
module tb_psx_poller;

    localparam int CLK_DIV     = 4;
    localparam int ATT_SETUP   = 8;
    localparam int ACK_TIMEOUT = 64;
    localparam int BYTE_GAP    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        data;
    logic        ack;
    logic        psx_clk;
    logic        cmd;
    logic        att;
    logic [15:0] buttons;
    logic        valid;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Pad configuration: reply bytes and per-byte ack behaviour
    // (mode 0 = pulse after ack_dly, 1 = never, 2 = held low across boundary).
    logic [7:0] reply    [5];
    int         ack_mode [4];
    int         ack_dly  [4];
    int         fresh_cyc;

    // Monitor observations.
    int         nrise;
    int         n_att_fall, n_att_rise, n_valid, n_error;
    int         last_rise_cyc, att_rise_cyc;
    int         byte_start_cyc [5];
    logic [7:0] cap [5];
    logic       att_d = 1'b1, att_d2 = 1'b1, mclk_d = 1'b1;

    // Model state.
    logic [15:0] exp_buttons;
    logic [15:0] exp_next;
    logic [7:0]  cmd_seq [5];

    psx_poller #(
        .CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
        .ACK_TIMEOUT(ACK_TIMEOUT), .BYTE_GAP(BYTE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .ack(ack),
        .psx_clk(psx_clk), .cmd(cmd), .att(att), .buttons(buttons),
        .valid(valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: bus idle levels, flag timing and payload, and bus capture.
    initial begin
        nrise = 0;
        forever begin
            @(negedge clk);
            if (att === 1'b1) chk("idle_bus_high", 32'({cmd, psx_clk}), 32'h3);
            if (valid === 1'b1 || error === 1'b1)
                chk("flags_exclusive", 32'(valid & error), 32'h0);
            if (valid === 1'b1) begin
                n_valid++;
                chk("valid_after_att_rise", 32'({att_d2, att_d, att}), 32'h3);
                chk("valid_buttons", 32'(buttons), 32'(exp_next));
                chk("valid_not_busy", 32'(busy), 32'h0);
            end
            if (error === 1'b1) begin
                n_error++;
                chk("error_after_att_rise", 32'({att_d2, att_d, att}), 32'h3);
            end
            if (att === 1'b0 && att_d) begin
                n_att_fall++;
                nrise = 0;
            end
            if (att === 1'b1 && !att_d) begin
                n_att_rise++;
                att_rise_cyc = cyc;
            end
            if (att === 1'b0 && nrise < 40) begin
                if (psx_clk && !mclk_d) begin
                    cap[nrise / 8][nrise % 8] = cmd;
                    nrise++;
                    last_rise_cyc = cyc;
                end else if (!psx_clk && mclk_d && (nrise % 8) == 0) begin
                    byte_start_cyc[nrise / 8] = cyc;
                end
            end
            att_d2 = att_d;
            att_d  = att;
            mclk_d = psx_clk;
        end
    end

    // Pad model: drives data on psx_clk falling edges, acks after bytes 0..3.
    initial begin
        int   pbit, pbyte, pk, pt;
        logic hold, pclk_d, ackv;
        data = 1'b1;
        ack  = 1'b1;
        pbit = 0; pbyte = 0; pk = 0; pt = -1; hold = 1'b0; pclk_d = 1'b1;
        forever begin
            @(negedge clk);
            if (att !== 1'b0) begin
                pbit = 0; pbyte = 0; pt = -1; hold = 1'b0; pclk_d = 1'b1;
                data = 1'b1;
                ack  = 1'b1;
            end else begin
                if (!psx_clk && pclk_d && pbyte < 5) data = reply[pbyte][pbit];
                if (psx_clk && !pclk_d) begin
                    pbit++;
                    if (pbyte < 4 && ack_mode[pbyte] == 2 && pbit == 6) hold = 1'b1;
                    if (pbit == 8) begin
                        pbit = 0;
                        if (pbyte < 4) begin
                            pk = pbyte;
                            pt = 0;
                        end
                        pbyte++;
                    end
                end
                ackv = 1'b1;
                if (pt >= 0) begin
                    if (ack_mode[pk] == 0 && pt >= ack_dly[pk] && pt < ack_dly[pk] + 4) ackv = 1'b0;
                    if (ack_mode[pk] == 2) begin
                        if (pt == 0) hold = 1'b0;
                        if (pt < ack_dly[pk]) ackv = 1'b0;
                        else if (pt >= ack_dly[pk] + 6 && pt < ack_dly[pk] + 10) ackv = 1'b0;
                        if (pt == ack_dly[pk] + 6) fresh_cyc = cyc;
                    end
                    pt++;
                    if (pt > 100) pt = -1;
                end
                if (hold) ackv = 1'b0;
                ack    = ackv;
                pclk_d = psx_clk;
            end
        end
    end

    task automatic set_normal(input logic [7:0] b3, input logic [7:0] b4);
        reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A;
        reply[3] = b3;    reply[4] = b4;
        for (int b = 0; b < 4; b++) begin
            ack_mode[b] = 0;
            ack_dly[b]  = 10;
        end
    endtask

    // One poll: predict the outcome from the pad configuration, run it, compare.
    task automatic run_poll(input bit spam, input string tag);
        bit   ack_ok, seen, done;
        int   to_byte, nbytes;
        logic exp_valid;
        ack_ok  = 1'b1;
        to_byte = 4;
        for (int b = 0; b < 4; b++)
            if (ack_mode[b] == 1 && ack_ok) begin
                ack_ok  = 1'b0;
                to_byte = b;
            end
        exp_valid = ack_ok && reply[1] == 8'h41 && reply[2] == 8'h5A;
        exp_next  = exp_valid ? {reply[4], reply[3]} : exp_buttons;
        nbytes    = ack_ok ? 5 : to_byte + 1;
        n_att_fall = 0; n_att_rise = 0; n_valid = 0; n_error = 0;

        @(negedge clk);
        start = 1'b1;
        if (!spam) begin
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
            if (spam && att === 1'b1 && busy === 1'b1) start = 1'b0;
            if (seen && busy === 1'b0) done = 1'b1;
        end
        start = 1'b0;
        chk({tag, " poll_completes"}, 32'(done), 32'h1);
        repeat (6) @(negedge clk);

        chk({tag, " att_fall_count"}, n_att_fall, 1);
        chk({tag, " att_rise_count"}, n_att_rise, 1);
        chk({tag, " valid_count"}, n_valid, 32'(exp_valid));
        chk({tag, " error_count"}, n_error, 32'(!exp_valid));
        if (exp_valid) exp_buttons = exp_next;
        chk({tag, " buttons"}, 32'(buttons), 32'(exp_buttons));
        for (int b = 0; b < nbytes; b++)
            chk($sformatf("%s cmd_byte%0d", tag, b), 32'(cap[b]), 32'(cmd_seq[b]));
        chk({tag, " idle_after"}, 32'({busy, att}), 32'h1);
    endtask

    // Safety net against a hung design.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  d;
        bit  reached;
        cmd_seq[0] = 8'h01; cmd_seq[1] = 8'h42;
        cmd_seq[2] = 8'h00; cmd_seq[3] = 8'h00; cmd_seq[4] = 8'h00;
        rst   = 1'b1;
        start = 1'b0;
        exp_buttons = 16'hFFFF;
        exp_next    = 16'hFFFF;
        set_normal(8'h7F, 8'hFF);

        repeat (3) @(negedge clk);
        chk("reset_bus", 32'({psx_clk, cmd, att}), 32'h7);
        chk("reset_buttons", 32'(buttons), 32'h0000FFFF);
        chk("reset_flags", 32'({valid, busy, error}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic poll: FF 41 5A 7F FF.
        set_normal(8'h7F, 8'hFF);
        run_poll(1'b0, "basic");
        chk("basic_buttons_literal", 32'(buttons), 32'h0000FF7F);

        // Wrong device ID.
        reply[1] = 8'h73;
        run_poll(1'b0, "bad_id");
        chk("bad_id_buttons_kept", 32'(buttons), 32'h0000FF7F);

        // Pad never acks byte 2.
        set_normal(8'h3C, 8'hA5);
        ack_mode[2] = 1;
        run_poll(1'b0, "timeout");
        chk("timeout_rises_seen", nrise, 24);
        chk("timeout_att_delay", att_rise_cyc - last_rise_cyc, CLK_DIV + ACK_TIMEOUT);
        set_normal(8'h3C, 8'hA5);
        run_poll(1'b0, "after_timeout");
        chk("after_timeout_literal", 32'(buttons), 32'h0000A53C);

        // start held high for the whole poll.
        set_normal(8'h12, 8'h34);
        run_poll(1'b1, "spam");

        // ack held low across the byte 1 boundary, released late, then a fresh fall.
        set_normal(8'hC3, 8'h5E);
        ack_mode[1] = 2;
        ack_dly[1]  = 20;
        run_poll(1'b0, "held_ack");
        d = byte_start_cyc[2] - fresh_cyc;
        chk_range("held_ack_restart_delay", d, BYTE_GAP + 2, BYTE_GAP + 4);

        // Reset during byte 3.
        set_normal(8'h00, 8'h00);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (nrise >= 28) reached = 1'b1;
        end
        chk("reset_test_reached_byte3", 32'(reached), 32'h1);
        rst = 1'b1;
        #1;
        chk("midpoll_reset_bus", 32'({att, psx_clk}), 32'h3);
        chk("midpoll_reset_buttons", 32'(buttons), 32'h0000FFFF);
        chk("midpoll_reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_buttons = 16'hFFFF;
        repeat (4) @(negedge clk);

        // Randomized polls.
        for (int it = 0; it < 10; it++) begin
            reply[0] = 8'hFF;
            reply[1] = ($urandom_range(0, 1) != 0) ? 8'h41 : 8'($urandom);
            reply[2] = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom);
            reply[3] = 8'($urandom);
            reply[4] = 8'($urandom);
            for (int b = 0; b < 4; b++) begin
                ack_mode[b] = 0;
                ack_dly[b]  = int'($urandom_range(4, 20));
            end
            if ($urandom_range(0, 4) == 0) ack_mode[$urandom_range(0, 3)] = 1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_poll(bit'($urandom_range(0, 1)), $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
